hash_word_pipe: RTL and testbench
=================================

# hash_word_pipe

Parametrised, fully pipelined Jenkins lookup3 `hashword` engine for the flow-table path. It hashes a variable-length key of 0..MAX_WORDS 32-bit words with a per-request initval, accepting one request per cycle. It carries a user tag alongside each request and uses valid/ready backpressure in place of a global stall. With MAX_WORDS=3 and key_len=3 it is bit-compatible with the existing 5-tuple hash and has the same 8-cycle latency.

## Interface
- MAX_WORDS, default 3: maximum key length in 32-bit words, must be ≥1.
- TAG_W, default 8: width of the opaque tag carried with each request, must be ≥1.
- Derived: NB = ceil(MAX_WORDS/3); LAT = 1 + 6·(NB−1) + 7.
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted when in_valid && in_ready.
- key  in  32·MAX_WORDS  word i = key[32i+31:32i]; word 0 feeds a, word 1 feeds b, word 2 feeds c.
- key_len  in  $clog2(MAX_WORDS+1)  number of valid words, 0..MAX_WORDS.
- initval  in  32  lookup3 initval.
- tag_in  in  TAG_W  carried unchanged to tag_out.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- hash  out  32  primary result (lookup3 c).
- hash_b  out  32  secondary result (lookup3 b, as in hashword2).
- tag_out  out  TAG_W  tag of the result.

## Operation
- Global enable: en = !out_valid || out_ready. in_ready = en, combinational from out_ready. Every pipeline register, valid bit and output advances only when en=1.
- Stage 0: a = b = c = 0xdeadbeef + (key_len<<2) + initval, mod 2^32. Key, key_len and tag are registered.
- Mix blocks j = 0..NB−2, 6 stages each. Block j is active iff key_len > 3(j+1).
- If block j is active:
  - the first stage adds words 3j, 3j+1 and 3j+2 to a, b and c before the first step;
  - the six stages then perform, one line per stage, in order:
    - a−=c; a^=rot(c,4); c+=b
    - b−=a; b^=rot(a,6); a+=c
    - c−=b; c^=rot(b,8); b+=a
    - a−=c; a^=rot(c,16); c+=b
    - b−=a; b^=rot(a,19); a+=c
    - c−=b; c^=rot(b,4); b+=a
- If block j is inactive, its six stages pass a, b and c through unchanged. Latency is therefore constant.
- Final block, 7 stages. Tail offset t = 3·(number of active mix blocks) and tail count n = key_len − t.
  - First stage adds word t to a if n≥1, word t+1 to b if n≥2, and word t+2 to c if n=3.
  - The seven stages then perform, in order:
    - c^=b; c−=rot(b,14)
    - a^=c; a−=rot(c,11)
    - b^=a; b−=rot(a,25)
    - c^=b; c−=rot(b,16)
    - a^=c; a−=rot(c,4)
    - b^=a; b−=rot(a,14)
    - c^=b; c−=rot(b,24)
- key_len = 0: the final block passes through with no tail add and no final. Output hash = hash_b = the stage-0 value.
- key_len > MAX_WORDS is illegal. It must not hang the pipeline. The result is unspecified but out_valid still fires.
- Key words at index ≥ key_len must never affect the result.
- rot(x,r) is a left rotate. All arithmetic is mod 2^32.

## Timing
- Reset values: out_valid=0; hash, hash_b and tag_out are 0; all internal valid bits are 0. Data registers are don't-care except the outputs.
- Latency: a request accepted at edge N produces out_valid at edge N+LAT, provided en stayed 1. Each cycle of en=0 adds one cycle. Example: LAT=8 for MAX_WORDS=3, LAT=26 for MAX_WORDS=12.
- Throughput: one request per cycle while out_ready=1.
- Bubbles are not compressed. Ordering is strictly FIFO.
- Backpressure: while out_valid && !out_ready, all outputs hold stable and in_ready=0. Data accepted before the stall is neither lost nor duplicated.
- Simultaneous accept and drain (en=1 with the output full) is legal. The pipeline shifts by one stage.
- Reset asserted mid-stream: all in-flight requests are discarded. out_valid=0 immediately (asynchronously). No stale result appears after rst_n deasserts.

## Test plan
- Use MAX_WORDS=3, key_len=3, and a stream of 100 random keys with a random initval, with out_ready=1. Each hash must equal the C reference `hashword(k,3,initval)`. Results appear exactly 8 cycles after acceptance at 1/cycle, with tags in order.
- Use key_len=0 with initval=0, then initval=1. hash = hash_b = 0xdeadbeef, then 0xdeadbef0.
- Use MAX_WORDS=12 and sweep key_len over 1..12 with random keys. Results must match C `hashword` and `hashword2`. Randomising words ≥ key_len must leave the result unchanged. Latency must be 26.
- Toggle out_ready randomly at 50% over 500 back-to-back requests. No result may be lost, duplicated or reordered. While stalled, outputs must stay stable and in_ready=0.
- Pulse rst_n low with 5 requests in flight, then send 1 request. Only that request's result emerges, and out_valid=0 throughout reset.

Source files
------------

// File: rtl/hash_word_pipe.sv
// hash_word_pipe: fully pipelined Jenkins lookup3 hashword engine.
// One request per cycle, constant latency of 1 + 6*(NB-1) + 7 register stages
// plus the output register. The whole pipe advances under one enable that
// drops only while the output is full and the consumer is not ready.
module hash_word_pipe #(
  parameter int MAX_WORDS = 3,
  parameter int TAG_W     = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [32*MAX_WORDS-1:0]        key,
  input  logic [$clog2(MAX_WORDS+1)-1:0] key_len,
  input  logic [31:0]                    initval,
  input  logic [TAG_W-1:0]               tag_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [31:0]                    hash,
  output logic [31:0]                    hash_b,
  output logic [TAG_W-1:0]               tag_out
);

  localparam int KW   = 32 * MAX_WORDS;
  localparam int LW   = $clog2(MAX_WORDS + 1);
  localparam int NB   = (MAX_WORDS + 2) / 3;
  localparam int NMIX = 6 * (NB - 1);
  localparam int LAT  = NMIX + 8;

  // Pipeline state. abc is packed as {a, b, c}. Keys are only kept until the
  // final block has consumed its tail words; lengths until the last stage.
  logic [95:0]      abc_r     [LAT];
  logic [95:0]      nxt_abc_s [LAT];
  logic [KW-1:0]    key_r     [NMIX+1];
  logic [LW-1:0]    len_r     [LAT-1];
  logic [TAG_W-1:0] tag_r     [LAT];
  logic [LAT-1:0]   vld_r;
  logic             en_s;
  logic [31:0]      init_s;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int r);
    return (x << r) | (x >> (32 - r));
  endfunction

  // Out-of-range indices (only reachable with an illegal key_len) read zero.
  function automatic logic [31:0] get_word(input logic [KW-1:0] k, input int idx);
    if (idx >= 0 && idx < MAX_WORDS) begin
      return k[32*idx +: 32];
    end else begin
      return 32'd0;
    end
  endfunction

  // One line of the lookup3 mix; block j is skipped when the key is too short.
  function automatic logic [95:0] mix_stage(input int j, input int k,
                                            input logic [95:0] abc,
                                            input logic [KW-1:0] kv,
                                            input logic [LW-1:0] len);
    logic [31:0] a, b, c;
    logic [2:0]  st;
    {a, b, c} = abc;
    st = 3'(k);
    if (int'(len) > 3 * (j + 1)) begin
      if (st == 3'd0) begin
        a = a + get_word(kv, 3 * j);
        b = b + get_word(kv, 3 * j + 1);
        c = c + get_word(kv, 3 * j + 2);
      end else begin
        a = a;
      end
      case (st)
        3'd0: begin a = a - c; a = a ^ rotl(c, 4);  c = c + b; end
        3'd1: begin b = b - a; b = b ^ rotl(a, 6);  a = a + c; end
        3'd2: begin c = c - b; c = c ^ rotl(b, 8);  b = b + a; end
        3'd3: begin a = a - c; a = a ^ rotl(c, 16); c = c + b; end
        3'd4: begin b = b - a; b = b ^ rotl(a, 19); a = a + c; end
        3'd5: begin c = c - b; c = c ^ rotl(b, 4);  b = b + a; end
        default: begin a = a; end
      endcase
    end else begin
      a = a;
    end
    return {a, b, c};
  endfunction

  // One line of the lookup3 final; the first line also folds in the tail.
  function automatic logic [95:0] fin_stage(input int k,
                                            input logic [95:0] abc,
                                            input logic [KW-1:0] kv,
                                            input logic [LW-1:0] len);
    logic [31:0] a, b, c;
    logic [2:0]  st;
    int          nact, t, n;
    {a, b, c} = abc;
    st = 3'(k);
    nact = 0;
    for (int j = 0; j < NB - 1; j++) begin
      nact = nact + ((int'(len) > 3 * (j + 1)) ? 1 : 0);
    end
    t = 3 * nact;
    n = int'(len) - t;
    if (len != {LW{1'b0}}) begin
      if (st == 3'd0) begin
        if (n >= 1) a = a + get_word(kv, t);     else a = a;
        if (n >= 2) b = b + get_word(kv, t + 1); else b = b;
        if (n >= 3) c = c + get_word(kv, t + 2); else c = c;
      end else begin
        a = a;
      end
      case (st)
        3'd0: begin c = c ^ b; c = c - rotl(b, 14); end
        3'd1: begin a = a ^ c; a = a - rotl(c, 11); end
        3'd2: begin b = b ^ a; b = b - rotl(a, 25); end
        3'd3: begin c = c ^ b; c = c - rotl(b, 16); end
        3'd4: begin a = a ^ c; a = a - rotl(c, 4);  end
        3'd5: begin b = b ^ a; b = b - rotl(a, 14); end
        3'd6: begin c = c ^ b; c = c - rotl(b, 24); end
        default: begin a = a; end
      endcase
    end else begin
      a = a;
    end
    return {a, b, c};
  endfunction

  assign en_s     = !out_valid || out_ready;
  assign in_ready = en_s;

  // Next-state of every a/b/c stage: seed, mix blocks, then the final block
  always_comb begin
    for (int s = 0; s < LAT; s++) begin
      nxt_abc_s[s] = 96'd0;
    end
    init_s       = 32'hdeadbeef + (32'(key_len) << 2) + initval;
    nxt_abc_s[0] = {init_s, init_s, init_s};
    for (int s = 1; s <= NMIX; s++) begin
      nxt_abc_s[s] = mix_stage((s - 1) / 6, (s - 1) % 6, abc_r[s-1], key_r[s-1], len_r[s-1]);
    end
    for (int k = 0; k < 7; k++) begin
      nxt_abc_s[NMIX+1+k] = fin_stage(k, abc_r[NMIX+k], key_r[NMIX], len_r[NMIX+k]);
    end
  end

  // Data pipeline shift; contents only matter where the matching valid bit is set
  always_ff @(posedge clk) begin
    if (en_s) begin
      for (int s = 0; s < LAT; s++) begin
        abc_r[s] <= nxt_abc_s[s];
      end
      tag_r[0] <= tag_in;
      for (int s = 1; s < LAT; s++) begin
        tag_r[s] <= tag_r[s-1];
      end
      key_r[0] <= key;
      for (int s = 1; s <= NMIX; s++) begin
        key_r[s] <= key_r[s-1];
      end
      len_r[0] <= key_len;
      for (int s = 1; s < LAT - 1; s++) begin
        len_r[s] <= len_r[s-1];
      end
    end
  end

  // Valid chain and output register; reset discards everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r     <= {LAT{1'b0}};
      out_valid <= 1'b0;
      hash      <= 32'd0;
      hash_b    <= 32'd0;
      tag_out   <= {TAG_W{1'b0}};
    end else if (en_s) begin
      vld_r     <= {vld_r[LAT-2:0], in_valid};
      out_valid <= vld_r[LAT-1];
      hash      <= abc_r[LAT-1][31:0];
      hash_b    <= abc_r[LAT-1][63:32];
      tag_out   <= tag_r[LAT-1];
    end
  end

endmodule

// File: tb/tb_hash_word_pipe.sv
// Scoreboard bench for hash_word_pipe: a 3-word and a 12-word instance.
// Drivers push expected results (lookup3 reference or hand constants) into
// queues; negedge monitors pop and compare whenever an output transfers.
module tb_hash_word_pipe;

  localparam int LAT3  = 8;
  localparam int LAT12 = 26;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // 3-word instance signals
  logic        in_valid3, in_ready3, out_valid3, out_ready3;
  logic [95:0] key3;
  logic [1:0]  key_len3;
  logic [31:0] initval3, hash3, hash_b3;
  logic [7:0]  tag_in3, tag_out3;
  // 12-word instance signals
  logic         in_valid12, in_ready12, out_valid12, out_ready12;
  logic [383:0] key12;
  logic [3:0]   key_len12;
  logic [31:0]  initval12, hash12, hash_b12;
  logic [7:0]   tag_in12, tag_out12;

  hash_word_pipe #(.MAX_WORDS(3), .TAG_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .key(key3), .key_len(key_len3), .initval(initval3), .tag_in(tag_in3),
    .out_valid(out_valid3), .out_ready(out_ready3), .hash(hash3),
    .hash_b(hash_b3), .tag_out(tag_out3));

  hash_word_pipe #(.MAX_WORDS(12), .TAG_W(8)) dut12 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid12), .in_ready(in_ready12),
    .key(key12), .key_len(key_len12), .initval(initval12), .tag_in(tag_in12),
    .out_valid(out_valid12), .out_ready(out_ready12), .hash(hash12),
    .hash_b(hash_b12), .tag_out(tag_out12));

  typedef struct {
    logic [31:0] h;
    logic [31:0] hb;
    logic [7:0]  tag;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t q3[$];
  exp_t q12[$];
  logic [7:0] tag3 = 8'd0;
  logic [7:0] tag12 = 8'd0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Straight C-style lookup3 hashword/hashword2 reference, returns {b, c}
  function automatic logic [31:0] rl(input logic [31:0] x, input int r);
    return (x << r) | (x >> (32 - r));
  endfunction

  function automatic logic [63:0] ref_hash(input logic [383:0] k, input int len, input logic [31:0] iv);
    logic [31:0] a, b, c;
    int rem, p;
    a = 32'hdeadbeef + (32'(len) << 2) + iv;
    b = a;
    c = a;
    rem = len;
    p = 0;
    while (rem > 3) begin
      a += k[32*p +: 32]; b += k[32*(p+1) +: 32]; c += k[32*(p+2) +: 32];
      a -= c; a ^= rl(c, 4);  c += b;
      b -= a; b ^= rl(a, 6);  a += c;
      c -= b; c ^= rl(b, 8);  b += a;
      a -= c; a ^= rl(c, 16); c += b;
      b -= a; b ^= rl(a, 19); a += c;
      c -= b; c ^= rl(b, 4);  b += a;
      rem -= 3;
      p += 3;
    end
    if (rem >= 3) c += k[32*(p+2) +: 32];
    if (rem >= 2) b += k[32*(p+1) +: 32];
    if (rem >= 1) begin
      a += k[32*p +: 32];
      c ^= b; c -= rl(b, 14);
      a ^= c; a -= rl(c, 11);
      b ^= a; b -= rl(a, 25);
      c ^= b; c -= rl(b, 16);
      a ^= c; a -= rl(c, 4);
      b ^= a; b -= rl(a, 14);
      c ^= b; c -= rl(b, 24);
    end
    return {b, c};
  endfunction

  // rmode: 0 = out_ready held 1, 1 = random 50%, 2 = held 0
  task automatic send3(input logic [95:0] k, input logic [1:0] len, input logic [31:0] iv,
                       input logic [63:0] expv, input bit lat, input int rmode);
    exp_t e;
    bit done;
    int tries;
    e.h = expv[31:0];
    e.hb = expv[63:32];
    e.tag = tag3;
    e.lat = lat;
    done = 1'b0;
    tries = 0;
    while (!done && tries < 400) begin
      @(posedge clk);
      #1;
      out_ready3 = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_valid3 = 1'b1;
      key3 = k;
      key_len3 = len;
      initval3 = iv;
      tag_in3 = tag3;
      #1;
      if (in_ready3) begin
        e.acc = cyc + 1;
        q3.push_back(e);
        done = 1'b1;
      end
      tries++;
    end
    if (!done) fail_now("send3_accept_timeout");
    tag3++;
  endtask

  task automatic drain3(input int rmode);
    int tries;
    tries = 0;
    while (q3.size() != 0 && tries < 3000) begin
      @(posedge clk);
      #1;
      in_valid3 = 1'b0;
      out_ready3 = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      tries++;
    end
    if (q3.size() != 0) fail_now("drain3_timeout");
    repeat (2) begin
      @(posedge clk);
      #1;
      out_ready3 = 1'b1;
    end
  endtask

  task automatic send12(input logic [383:0] k, input logic [3:0] len, input logic [31:0] iv,
                        input logic [63:0] expv);
    exp_t e;
    bit done;
    int tries;
    e.h = expv[31:0];
    e.hb = expv[63:32];
    e.tag = tag12;
    e.lat = 1'b1;
    done = 1'b0;
    tries = 0;
    while (!done && tries < 100) begin
      @(posedge clk);
      #1;
      in_valid12 = 1'b1;
      key12 = k;
      key_len12 = len;
      initval12 = iv;
      tag_in12 = tag12;
      #1;
      if (in_ready12) begin
        e.acc = cyc + 1;
        q12.push_back(e);
        done = 1'b1;
      end
      tries++;
    end
    if (!done) fail_now("send12_accept_timeout");
    tag12++;
  endtask

  // Monitor for the 3-word instance: transfers, stall stability, reset
  logic [72:0] hold3;
  bit          hold3_v = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold3_v = 1'b0;
      chk("rst_out_valid3", 80'(out_valid3), 80'(0));
    end else begin
      if (hold3_v) begin
        chk("stall_hold3", 80'({out_valid3, hash3, hash_b3, tag_out3}), 80'(hold3));
        hold3_v = 1'b0;
      end
      if (out_valid3 && !out_ready3) begin
        chk("stall_in_ready3", 80'(in_ready3), 80'(0));
        hold3 = {out_valid3, hash3, hash_b3, tag_out3};
        hold3_v = 1'b1;
      end else if (out_valid3) begin
        if (q3.size() == 0) begin
          fail_now($sformatf("unexpected_out3 tag %0h", tag_out3));
        end else begin
          e = q3.pop_front();
          chk("hash3", 80'(hash3), 80'(e.h));
          chk("hash_b3", 80'(hash_b3), 80'(e.hb));
          chk("tag3", 80'(tag_out3), 80'(e.tag));
          if (e.lat) chk("latency3", 80'(cyc - e.acc), 80'(LAT3));
        end
      end
    end
  end

  // Monitor for the 12-word instance (consumer always ready)
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid12) begin
      if (q12.size() == 0) begin
        fail_now($sformatf("unexpected_out12 tag %0h", tag_out12));
      end else begin
        e = q12.pop_front();
        chk("hash12", 80'(hash12), 80'(e.h));
        chk("hash_b12", 80'(hash_b12), 80'(e.hb));
        chk("tag12", 80'(tag_out12), 80'(e.tag));
        chk("latency12", 80'(cyc - e.acc), 80'(LAT12));
      end
    end
  end

  initial begin
    logic [95:0]  k3;
    logic [383:0] k, k2;
    logic [31:0]  iv;
    logic [1:0]   l3;
    int tries;

    rst_n = 1'b0;
    in_valid3 = 1'b0; out_ready3 = 1'b1; key3 = 96'd0; key_len3 = 2'd0;
    initval3 = 32'd0; tag_in3 = 8'd0;
    in_valid12 = 1'b0; out_ready12 = 1'b1; key12 = 384'd0; key_len12 = 4'd0;
    initval12 = 32'd0; tag_in12 = 8'd0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_out_valid3", 80'(out_valid3), 80'(0));
    chk("reset_hash3", 80'({hash3, hash_b3, tag_out3}), 80'(0));
    chk("reset_out_valid12", 80'(out_valid12), 80'(0));
    chk("reset_hash12", 80'({hash12, hash_b12, tag_out12}), 80'(0));
    #1;
    rst_n = 1'b1;

    // 100 back-to-back 3-word keys, one initval, consumer always ready
    iv = $urandom();
    for (int i = 0; i < 100; i++) begin
      k3 = {$urandom(), $urandom(), $urandom()};
      send3(k3, 2'd3, iv, ref_hash({288'd0, k3}, 3, iv), 1'b1, 0);
    end
    // empty key: result is the seed value, key words must be ignored
    send3({$urandom(), $urandom(), $urandom()}, 2'd0, 32'd0, {32'hdeadbeef, 32'hdeadbeef}, 1'b1, 0);
    send3({$urandom(), $urandom(), $urandom()}, 2'd0, 32'd1, {32'hdeadbef0, 32'hdeadbef0}, 1'b1, 0);
    drain3(0);

    // 12-word sweep; rerun each length with garbage beyond key_len
    for (int len = 1; len <= 12; len++) begin
      for (int w = 0; w < 12; w++) k[32*w +: 32] = $urandom();
      k2 = k;
      for (int w = len; w < 12; w++) k2[32*w +: 32] = $urandom();
      iv = $urandom();
      send12(k, 4'(len), iv, ref_hash(k, len, iv));
      send12(k2, 4'(len), iv, ref_hash(k, len, iv));
    end
    @(posedge clk);
    #1;
    in_valid12 = 1'b0;
    tries = 0;
    while (q12.size() != 0 && tries < 200) begin
      @(posedge clk);
      tries++;
    end
    if (q12.size() != 0) fail_now("drain12_timeout");

    // 500 requests under random backpressure
    for (int i = 0; i < 500; i++) begin
      k3 = {$urandom(), $urandom(), $urandom()};
      l3 = 2'($urandom_range(0, 3));
      iv = $urandom();
      send3(k3, l3, iv, ref_hash({288'd0, k3}, int'(l3), iv), 1'b0, 1);
    end
    drain3(1);

    // reset with 5 requests in flight and one result parked at the output
    for (int i = 0; i < 5; i++) begin
      k3 = {$urandom(), $urandom(), $urandom()};
      iv = $urandom();
      send3(k3, 2'd3, iv, ref_hash({288'd0, k3}, 3, iv), 1'b0, 2);
    end
    tries = 0;
    do begin
      @(posedge clk);
      #1;
      in_valid3 = 1'b0;
      out_ready3 = 1'b0;
      tries++;
    end while (!out_valid3 && tries < 50);
    if (!out_valid3) fail_now("reset_setup_timeout");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_clear_out_valid3", 80'(out_valid3), 80'(0));
    q3.delete();
    repeat (3) @(posedge clk);
    #3;
    out_ready3 = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_reset3", 80'(in_ready3), 80'(1));
    k3 = {$urandom(), $urandom(), $urandom()};
    iv = $urandom();
    send3(k3, 2'd3, iv, ref_hash({288'd0, k3}, 3, iv), 1'b1, 0);
    drain3(0);
    repeat (12) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
